// File: rtl/program_feeder.sv
// Instruction source for the CPU: holds a host-loaded program and feeds one byte per LoadIRSig.
// Holds the CPU in reset until a run starts; presents HALT_OPCODE once the program is exhausted.
module program_feeder #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  HALT_OPCODE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              LoadIRSig,
  output logic [7:0]        instruction,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   pc,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     Depth  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthW = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PcOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] Addr0 = '0;

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic [ADDR_W:0] len_clamped;
  logic            mem_we;

  logic [7:0] mem [Depth];

  assign len_clamped = (prog_len > DepthW) ? DepthW : prog_len;
  assign mem_we      = wr_en && (state_q == StIdle) && !reset;

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    cpu_reset_d = cpu_reset_q;

    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      pc_d        = '0;
      instr_d     = 8'h00;
      cpu_reset_d = 1'b1;
    end else if (start && !abort && ((state_q == StIdle) || (state_q == StDone))) begin
      len_d = len_clamped;
      pc_d  = '0;
      if (len_clamped == '0) begin
        state_d     = StDone;
        instr_d     = HALT_OPCODE;
        cpu_reset_d = 1'b0;
      end else begin
        // A re-run from DONE puts the CPU back in reset for the priming cycle.
        state_d     = StPrime;
        cpu_reset_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StPrime: begin
          instr_d     = mem[Addr0];
          pc_d        = PcOne;
          cpu_reset_d = 1'b0;
          state_d     = StRun;
        end
        StRun: begin
          if (LoadIRSig) begin
            if (pc_q < len_q) begin
              instr_d = mem[pc_q[ADDR_W-1:0]];
              pc_d    = pc_q + PcOne;
            end else begin
              instr_d = HALT_OPCODE;
              state_d = StDone;
            end
          end
        end
        StDone: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      pc_q        <= '0;
      instr_q     <= 8'h00;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign instruction = instr_q;
  assign cpu_reset   = cpu_reset_q;
  assign pc          = pc_q;
  assign busy        = (state_q == StPrime) || (state_q == StRun);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_program_feeder.sv
// Self-checking bench for program_feeder: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a program-snapshot reference model.
module tb_program_feeder;

  localparam int unsigned AW   = 4;
  localparam int unsigned DEP  = 16;
  localparam logic [7:0]  HALT = 8'hEE;

  logic          clk = 1'b0;
  logic          reset, wr_en, start, abort, LoadIRSig;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   prog_len;
  logic [7:0]    instruction;
  logic          cpu_reset, busy, done;
  logic [AW:0]   pc;

  program_feeder #(.ADDR_W(AW), .HALT_OPCODE(HALT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start), .abort(abort), .LoadIRSig(LoadIRSig),
    .instruction(instruction), .cpu_reset(cpu_reset), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a run is a snapshot of the first len bytes, consumed in order.
  logic [7:0] m_mem [DEP];
  logic [7:0] m_prog [$];
  int         m_mode;   // 0 idle, 1 priming, 2 running, 3 finished
  int         m_pc;
  logic [7:0] m_instr;
  logic       m_cr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int len;
    if (reset) begin
      m_mode = 0; m_instr = 8'h00; m_pc = 0; m_cr = 1'b1;
      return;
    end
    if (m_mode == 0 && wr_en) m_mem[wr_addr] = wr_data;
    if (abort) begin
      if (m_mode != 0) begin
        m_mode = 0; m_instr = 8'h00; m_pc = 0; m_cr = 1'b1;
      end
      return;
    end
    if (start && (m_mode == 0 || m_mode == 3)) begin
      len = (int'(prog_len) > DEP) ? DEP : int'(prog_len);
      m_prog.delete();
      for (int i = 0; i < len; i++) m_prog.push_back(m_mem[i]);
      m_pc = 0;
      if (len == 0) begin
        m_mode = 3; m_instr = HALT; m_cr = 1'b0;
      end else begin
        m_mode = 1; m_cr = 1'b1;
      end
      return;
    end
    if (m_mode == 1) begin
      m_instr = m_prog[0]; m_pc = 1; m_cr = 1'b0; m_mode = 2;
    end else if (m_mode == 2 && LoadIRSig) begin
      if (m_pc < m_prog.size()) begin
        m_instr = m_prog[m_pc]; m_pc++;
      end else begin
        m_instr = HALT; m_mode = 3;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("model_instruction", instruction, m_instr);
    chk("model_cpu_reset", cpu_reset, m_cr);
    chk("model_pc", pc, m_pc);
    chk("model_busy", busy, (m_mode == 1 || m_mode == 2));
    chk("model_done", done, (m_mode == 3));
  endtask

  task automatic setin(input logic rs, input logic we, input int wa, input int wd, input int pl,
                       input logic st, input logic ab, input logic ld);
    reset = rs; wr_en = we; wr_addr = AW'(wa); wr_data = 8'(wd);
    prog_len = (AW + 1)'(pl); start = st; abort = ab; LoadIRSig = ld;
  endtask

  task automatic expect_out(input string name, input int ins, input logic cr, input int p,
                            input logic bz, input logic dn);
    chk({name, "_instruction"}, instruction, ins);
    chk({name, "_cpu_reset"}, cpu_reset, cr);
    chk({name, "_pc"}, pc, p);
    chk({name, "_busy"}, busy, bz);
    chk({name, "_done"}, done, dn);
  endtask

  typedef struct packed {
    logic rs; logic we; logic [3:0] wa; logic [7:0] wd; logic [4:0] pl;
    logic st; logic ab; logic ld;
    logic [7:0] e_ins; logic e_cr; logic [4:0] e_pc; logic e_bz; logic e_dn;
  } vec_t;

  function automatic vec_t mkv(logic rs, logic we, int wa, int wd, int pl, logic st, logic ab,
                               logic ld, int ins, logic cr, int p, logic bz, logic dn);
    vec_t v;
    v.rs = rs; v.we = we; v.wa = 4'(wa); v.wd = 8'(wd); v.pl = 5'(pl);
    v.st = st; v.ab = ab; v.ld = ld;
    v.e_ins = 8'(ins); v.e_cr = cr; v.e_pc = 5'(p); v.e_bz = bz; v.e_dn = dn;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    //              rs we wa wd    pl st ab ld   ins    cr pc bz dn
    vecs[0]  = mkv(1, 0, 0, 0,     0, 0, 0, 0,  8'h00, 1, 0, 0, 0);
    vecs[1]  = mkv(0, 1, 0, 8'h11, 0, 0, 0, 0,  8'h00, 1, 0, 0, 0);
    vecs[2]  = mkv(0, 1, 1, 8'h22, 0, 0, 0, 0,  8'h00, 1, 0, 0, 0);
    vecs[3]  = mkv(0, 1, 2, 8'h33, 3, 1, 0, 0,  8'h00, 1, 0, 1, 0);  // write lands with start
    vecs[4]  = mkv(0, 0, 0, 0,     0, 0, 0, 0,  8'h11, 0, 1, 1, 0);
    vecs[5]  = mkv(0, 0, 0, 0,     0, 0, 0, 1,  8'h22, 0, 2, 1, 0);
    vecs[6]  = mkv(0, 0, 0, 0,     0, 0, 0, 0,  8'h22, 0, 2, 1, 0);
    vecs[7]  = mkv(0, 0, 0, 0,     0, 0, 0, 0,  8'h22, 0, 2, 1, 0);
    vecs[8]  = mkv(0, 0, 0, 0,     0, 0, 0, 1,  8'h33, 0, 3, 1, 0);
    vecs[9]  = mkv(0, 0, 0, 0,     0, 0, 0, 0,  8'h33, 0, 3, 1, 0);
    vecs[10] = mkv(0, 0, 0, 0,     0, 0, 0, 0,  8'h33, 0, 3, 1, 0);
    vecs[11] = mkv(0, 0, 0, 0,     0, 0, 0, 1,  HALT,  0, 3, 0, 1);
    vecs[12] = mkv(0, 0, 0, 0,     0, 0, 0, 1,  HALT,  0, 3, 0, 1);
    vecs[13] = mkv(0, 0, 0, 0,     0, 0, 1, 0,  8'h00, 1, 0, 0, 0);
    vecs[14] = mkv(0, 0, 0, 0,     0, 1, 0, 0,  HALT,  0, 0, 0, 1);  // empty program
    vecs[15] = mkv(0, 0, 0, 0,     0, 0, 1, 0,  8'h00, 1, 0, 0, 0);

    setin(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < DEP; i++) begin
      setin(0, 1, i, $urandom_range(0, 255), 0, 0, 0, 0);
      step();
    end

    for (int i = 0; i < 16; i++) begin
      setin(vecs[i].rs, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].pl,
            vecs[i].st, vecs[i].ab, vecs[i].ld);
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].e_ins, vecs[i].e_cr, vecs[i].e_pc,
                 vecs[i].e_bz, vecs[i].e_dn);
    end

    // LoadIRSig held high: one byte per cycle, then HALT stays put.
    for (int i = 0; i < 4; i++) begin
      setin(0, 1, i, 8'hA0 + i, 0, 0, 0, 0);
      step();
    end
    setin(0, 0, 0, 0, 4, 1, 0, 0); step();
    setin(0, 0, 0, 0, 0, 0, 0, 0); step();
    expect_out("held_first", 8'hA0, 0, 1, 1, 0);
    setin(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      expect_out($sformatf("held_%0d", i), 8'hA0 + i, 0, i + 1, 1, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("held_halt%0d", i), HALT, 0, 4, 0, 1);
    end

    // Abort and reset mid-run, then replay from the start.
    setin(0, 0, 0, 0, 0, 0, 1, 0); step();
    for (int i = 0; i < 5; i++) begin
      setin(0, 1, i, 8'h50 + i, 0, 0, 0, 0);
      step();
    end
    setin(0, 0, 0, 0, 5, 1, 0, 0); step();
    setin(0, 0, 0, 0, 0, 0, 0, 0); step();
    setin(0, 0, 0, 0, 0, 0, 0, 1); step();
    expect_out("pre_abort", 8'h51, 0, 2, 1, 0);
    setin(0, 0, 0, 0, 0, 0, 1, 0); step();
    expect_out("abort", 8'h00, 1, 0, 0, 0);
    setin(0, 0, 0, 0, 5, 1, 0, 0); step();
    setin(0, 0, 0, 0, 0, 0, 0, 0); step();
    expect_out("replay", 8'h50, 0, 1, 1, 0);
    setin(0, 0, 0, 0, 0, 0, 0, 1); step();
    setin(1, 0, 0, 0, 0, 0, 0, 1); step();
    expect_out("midrun_reset", 8'h00, 1, 0, 0, 0);

    // Writes during a run must not reach memory.
    setin(0, 0, 0, 0, 5, 1, 0, 0); step();
    setin(0, 0, 0, 0, 0, 0, 0, 0); step();
    setin(0, 1, 1, 8'hAA, 0, 0, 0, 1); step();
    expect_out("run_write", 8'h51, 0, 2, 1, 0);
    setin(0, 0, 0, 0, 0, 0, 1, 0); step();
    setin(0, 0, 0, 0, 5, 1, 0, 0); step();
    setin(0, 0, 0, 0, 0, 0, 0, 0); step();
    setin(0, 0, 0, 0, 0, 0, 0, 1); step();
    expect_out("rerun_mem1", 8'h51, 0, 2, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      setin(($urandom % 64) == 0, $urandom % 2, $urandom_range(0, DEP - 1),
            $urandom_range(0, 255), $urandom_range(0, 20), ($urandom % 8) == 0,
            ($urandom % 32) == 0, $urandom % 2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
